flappy_game_ctrl: RTL and testbench

Per-frame game sequencer for the Flappy Bird display path. It runs in the pixel clock domain and takes the pixel-timing counters and the raw push-button. It owns the game state machine, bird physics, pipe scrolling, collision and score. It publishes registered geometry and state that the pixel painter reads combinationally. All state updates happen once per frame, in vertical blanking, so the painted image never tears.

---
 rtl/flappy_game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird per-frame game sequencer.
// Runs in the pixel clock domain. Button synchronisation, the frame tick, the
// game FSM, bird physics, pipe scrolling, collision and score all live here.
// Geometry and state are registered so the painter can read them freely; they
// only change on the frame_tick cycle, which falls inside vertical blanking.
module flappy_game_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BIRD_X       = 160,
    parameter int BIRD_SIZE    = 20,
    parameter int BIRD_START_Y = 220,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 8,
    parameter int VMAX         = 10,
    parameter int PIPE_W       = 60,
    parameter int PIPE_GAP     = 120,
    parameter int PIPE_SPEED   = 2,
    parameter int GAP_MIN      = 60,
    parameter int GROUND_Y     = 440,
    parameter int DEAD_HOLD    = 30
) (
    input  logic        pix_clk,
    input  logic        pix_rstn,
    input  logic [15:0] sx,
    input  logic [15:0] sy,
    input  logic        button,
    output logic [1:0]  game_state,
    output logic [15:0] bird_y,
    output logic [15:0] pipe_x,
    output logic [15:0] gap_y,
    output logic [7:0]  score,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Home geometry and tick position at output width.
    localparam logic [15:0] START_Y   = 16'(BIRD_START_Y);
    localparam logic [15:0] PIPE_HOME = 16'(H_ACTIVE);
    localparam logic [15:0] GAP_HOME  = 16'(GAP_MIN + 100);
    localparam logic [15:0] GAP_BASE  = 16'(GAP_MIN);
    localparam logic [15:0] PIPE_STEP = 16'(PIPE_SPEED);
    localparam logic [15:0] V_TICK    = 16'(V_ACTIVE);
    localparam logic [7:0]  HOLD_MAX  = 8'(DEAD_HOLD);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    // Velocity constants (signed, negative is upward).
    localparam logic signed [11:0] V_FLAP = 12'(-FLAP_VEL);
    localparam logic signed [11:0] V_GRAV = 12'(GRAVITY);
    localparam logic signed [11:0] V_MAX  = 12'(VMAX);

    // Collision constants widened to 18 bits so no sum can wrap.
    localparam logic signed [17:0] S_SIZE   = 18'(BIRD_SIZE);
    localparam logic signed [17:0] S_GROUND = 18'(GROUND_Y);
    localparam logic signed [17:0] S_BIRD_X = 18'(BIRD_X);
    localparam logic signed [17:0] S_PIPE_W = 18'(PIPE_W);
    localparam logic signed [17:0] S_GAP    = 18'(PIPE_GAP);

    state_e             state_q, state_d;
    logic [15:0]        bird_y_q, bird_y_d;
    logic [15:0]        pipe_x_q, pipe_x_d;
    logic [15:0]        gap_y_q, gap_y_d;
    logic [7:0]         score_q, score_d;
    logic signed [11:0] vel_q, vel_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         hold_q, hold_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               btn_prev_q, btn_prev_d;
    logic               flap_req_q, flap_req_d;
    logic               tick_cond_q, tick_cond_d;
    logic               frame_tick_q, frame_tick_d;

    logic               btn_rise;
    logic               tick_cond;
    logic signed [11:0] vel_sum;
    logic signed [11:0] vel_play;
    logic signed [17:0] ny_s;
    logic               pipe_wrap;
    logic [15:0]        pipe_nx;
    logic [15:0]        gap_nx;
    logic [7:0]         score_nx;
    logic signed [17:0] pipe_s;
    logic signed [17:0] gap_s;
    logic               overlap;
    logic               gap_miss;
    logic               dies;

    // Candidate PLAY-frame physics: new velocity, bird, pipe and the death test.
    always_comb begin
        vel_sum   = vel_q + V_GRAV;
        vel_play  = flap_req_q ? V_FLAP : ((vel_sum > V_MAX) ? V_MAX : vel_sum);
        ny_s      = $signed({2'b00, bird_y_q}) + $signed({{6{vel_play[11]}}, vel_play});
        pipe_wrap = (pipe_x_q <= PIPE_STEP);
        pipe_nx   = pipe_wrap ? PIPE_HOME : (pipe_x_q - PIPE_STEP);
        gap_nx    = pipe_wrap ? (GAP_BASE + {8'd0, lfsr_q}) : gap_y_q;
        score_nx  = (pipe_wrap && (score_q != 8'hFF)) ? (score_q + 8'd1) : score_q;
        pipe_s    = $signed({2'b00, pipe_nx});
        gap_s     = $signed({2'b00, gap_nx});
        overlap   = (pipe_s < (S_BIRD_X + S_SIZE)) && ((pipe_s + S_PIPE_W) > S_BIRD_X);
        gap_miss  = (ny_s < gap_s) || ((ny_s + S_SIZE) > (gap_s + S_GAP));
        dies      = (ny_s < 18'sd0) || ((ny_s + S_SIZE) >= S_GROUND) || (overlap && gap_miss);
    end

    // Next-state logic: button path, frame tick, LFSR and the game FSM.
    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can infer a latch.
        state_d      = state_q;
        bird_y_d     = bird_y_q;
        pipe_x_d     = pipe_x_q;
        gap_y_d      = gap_y_q;
        score_d      = score_q;
        vel_d        = vel_q;
        hold_d       = hold_q;

        sync1_d      = button;
        sync2_d      = sync1_q;
        btn_prev_d   = sync2_q;
        btn_rise     = sync2_q & ~btn_prev_q;
        // A rise in the tick cycle wins over the clear, so it carries to next frame.
        flap_req_d   = btn_rise | (flap_req_q & ~frame_tick_q);

        tick_cond    = (sx == 16'd0) && (sy == V_TICK);
        tick_cond_d  = tick_cond;
        frame_tick_d = tick_cond & ~tick_cond_q;

        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (frame_tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (flap_req_q) begin
                        // The first flap already lifts the bird off its perch.
                        state_d  = ST_PLAY;
                        vel_d    = V_FLAP;
                        bird_y_d = ny_s[15:0];
                        score_d  = 8'd0;
                    end
                end
                ST_PLAY: begin
                    vel_d    = vel_play;
                    bird_y_d = (ny_s < 18'sd0) ? 16'd0 : ny_s[15:0];
                    pipe_x_d = pipe_nx;
                    gap_y_d  = gap_nx;
                    score_d  = score_nx;
                    if (dies) begin
                        state_d = ST_DEAD;
                        hold_d  = 8'd0;
                    end
                end
                ST_DEAD: begin
                    if (flap_req_q && (hold_q == HOLD_MAX)) begin
                        state_d  = ST_IDLE;
                        bird_y_d = START_Y;
                        pipe_x_d = PIPE_HOME;
                        gap_y_d  = GAP_HOME;
                        vel_d    = '0;
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: begin
                    // Unused encoding recovers to a clean IDLE.
                    state_d  = ST_IDLE;
                    bird_y_d = START_Y;
                    pipe_x_d = PIPE_HOME;
                    gap_y_d  = GAP_HOME;
                    vel_d    = '0;
                end
            endcase
        end
    end

    // All registers, asynchronously cleared to the IDLE home position.
    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            state_q      <= ST_IDLE;
            bird_y_q     <= START_Y;
            pipe_x_q     <= PIPE_HOME;
            gap_y_q      <= GAP_HOME;
            score_q      <= 8'd0;
            vel_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            hold_q       <= 8'd0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            btn_prev_q   <= 1'b0;
            flap_req_q   <= 1'b0;
            tick_cond_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q      <= state_d;
            bird_y_q     <= bird_y_d;
            pipe_x_q     <= pipe_x_d;
            gap_y_q      <= gap_y_d;
            score_q      <= score_d;
            vel_q        <= vel_d;
            lfsr_q       <= lfsr_d;
            hold_q       <= hold_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            btn_prev_q   <= btn_prev_d;
            flap_req_q   <= flap_req_d;
            tick_cond_q  <= tick_cond_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign game_state = state_q;
    assign bird_y     = bird_y_q;
    assign pipe_x     = pipe_x_q;
    assign gap_y      = gap_y_q;
    assign score      = score_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Testbench for flappy_game_ctrl: a compressed frame generator drives sx/sy,
// a game-rules model predicts each frame update into a queue, and a monitor
// pops and compares whenever the DUT raises frame_tick.
module tb_flappy_game_ctrl;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BIRD_X       = 160;
    localparam int BIRD_SIZE    = 20;
    localparam int BIRD_START_Y = 220;
    localparam int GRAVITY      = 1;
    localparam int FLAP_VEL     = 8;
    localparam int VMAX         = 10;
    localparam int PIPE_W       = 60;
    localparam int PIPE_GAP     = 120;
    localparam int PIPE_SPEED   = 2;
    localparam int GAP_MIN      = 60;
    localparam int GROUND_Y     = 440;
    localparam int DEAD_HOLD    = 30;

    // Compressed frame: 8 columns x 6 lines (477..482); (0,480) is index 24.
    localparam int FRAME_LEN = 48;
    localparam int COND_IDX  = 24;

    logic        pix_clk = 1'b0;
    logic        pix_rstn = 1'b0;
    logic [15:0] sx = '0;
    logic [15:0] sy = '0;
    logic        button = 1'b0;
    logic [1:0]  game_state;
    logic [15:0] bird_y;
    logic [15:0] pipe_x;
    logic [15:0] gap_y;
    logic [7:0]  score;
    logic        frame_tick;

    flappy_game_ctrl dut (
        .pix_clk    (pix_clk),
        .pix_rstn   (pix_rstn),
        .sx         (sx),
        .sy         (sy),
        .button     (button),
        .game_state (game_state),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .score      (score),
        .frame_tick (frame_tick)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        int cyc;
        int st;
        int bird;
        int pipe;
        int gap;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Game-rules model state.
    int m_state, m_bird, m_vel, m_pipe, m_gap, m_score, m_hold, m_lfsr;
    bit m_pending, m_carry, m_prev_cond;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    task automatic model_reset();
        m_state     = 0;
        m_bird      = BIRD_START_Y;
        m_vel       = 0;
        m_pipe      = H_ACTIVE;
        m_gap       = GAP_MIN + 100;
        m_score     = 0;
        m_hold      = 0;
        m_lfsr      = 8'hA5;
        m_pending   = 1'b0;
        m_carry     = 1'b0;
        m_prev_cond = 1'b0;
    endtask

    // One frame update by the game rules; the predicted result goes in the queue.
    task automatic model_tick();
        bit flap;
        bit die;
        int ny;
        flap      = m_pending;
        m_pending = 1'b0;
        case (m_state)
            0: begin
                if (flap) begin
                    m_state = 1;
                    m_vel   = -FLAP_VEL;
                    m_bird  = BIRD_START_Y - FLAP_VEL;
                    m_score = 0;
                end
            end
            1: begin
                if (flap) m_vel = -FLAP_VEL;
                else m_vel = (m_vel + GRAVITY > VMAX) ? VMAX : m_vel + GRAVITY;
                ny  = m_bird + m_vel;
                die = 1'b0;
                if (ny < 0) begin
                    m_bird = 0;
                    die    = 1'b1;
                end else begin
                    m_bird = ny;
                end
                if (m_pipe <= PIPE_SPEED) begin
                    m_pipe = H_ACTIVE;
                    m_gap  = GAP_MIN + m_lfsr;
                    if (m_score < 255) m_score++;
                end else begin
                    m_pipe -= PIPE_SPEED;
                end
                if (ny + BIRD_SIZE >= GROUND_Y) die = 1'b1;
                if (m_pipe < BIRD_X + BIRD_SIZE && m_pipe + PIPE_W > BIRD_X &&
                    (ny < m_gap || ny + BIRD_SIZE > m_gap + PIPE_GAP)) die = 1'b1;
                if (die) begin
                    m_state = 2;
                    m_hold  = 0;
                end
            end
            default: begin
                if (flap && m_hold == DEAD_HOLD) begin
                    m_state = 0;
                    m_bird  = BIRD_START_Y;
                    m_pipe  = H_ACTIVE;
                    m_gap   = GAP_MIN + 100;
                    m_vel   = 0;
                end else if (m_hold < DEAD_HOLD) begin
                    m_hold++;
                end
            end
        endcase
        exp_q.push_back('{cyc, m_state, m_bird, m_pipe, m_gap, m_score});
    endtask

    // Drive one pixel position; the tick is predicted when (0,480) first appears.
    task automatic drive_cycle(input int x, input int y, input bit b);
        bit cond;
        sx     = 16'(x);
        sy     = 16'(y);
        button = b;
        @(posedge pix_clk);
        cyc++;
        if (pix_rstn) begin
            m_lfsr = lfsr_step(m_lfsr);
            cond   = (x == 0) && (y == V_ACTIVE);
            if (cond && !m_prev_cond) model_tick();
            m_prev_cond = cond;
        end
        #1;
    endtask

    task automatic check_home(input string tag);
        check({tag, "_state"}, int'(game_state), 0);
        check({tag, "_bird_y"}, int'(bird_y), BIRD_START_Y);
        check({tag, "_pipe_x"}, int'(pipe_x), H_ACTIVE);
        check({tag, "_gap_y"}, int'(gap_y), GAP_MIN + 100);
    endtask

    // Reset asserted between clock edges, checked before the next edge.
    task automatic async_reset_here();
        #2;
        pix_rstn = 1'b0;
        model_reset();
        #1;
        check_home("async_rst");
        check("async_rst_score", int'(score), 0);
        check("async_rst_tick", int'(frame_tick), 0);
        repeat (2) begin
            @(posedge pix_clk);
            cyc++;
        end
        #2;
        pix_rstn = 1'b1;
    endtask

    // One frame; press_idx < 0 means no press. A rise from press index <= 22
    // lands before the tick; index 23 lands on the tick cycle and carries over.
    task automatic run_frame(input int press_idx, input int cond_reps, input int rst_idx);
        int reps;
        bit b;
        m_pending = m_pending | m_carry;
        m_carry   = 1'b0;
        if (press_idx >= 0) begin
            if (press_idx <= COND_IDX - 2) m_pending = 1'b1;
            else m_carry = 1'b1;
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            reps = (i == COND_IDX) ? cond_reps : 1;
            b    = (press_idx >= 0) && (i >= press_idx) && (i < press_idx + 3);
            for (int r = 0; r < reps; r++) drive_cycle(i % 8, 477 + i / 8, b);
            if (i == rst_idx) async_reset_here();
        end
    endtask

    function automatic int rand_press();
        return int'($urandom_range(0, COND_IDX - 2));
    endfunction

    // Monitor: on every frame_tick pop a prediction, then compare the outputs
    // on the following cycle once the update is visible.
    initial begin : monitor
        exp_t e;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge pix_clk);
            if (pend) begin
                check("state", int'(game_state), e.st);
                check("bird_y", int'(bird_y), e.bird);
                check("pipe_x", int'(pipe_x), e.pipe);
                check("gap_y", int'(gap_y), e.gap);
                check("score", int'(score), e.score);
                pend = 1'b0;
            end
            if (frame_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_tick: actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        int n;
        model_reset();
        #12;
        check_home("por");
        check("por_score", int'(score), 0);
        check("por_tick", int'(frame_tick), 0);
        #1;
        pix_rstn = 1'b1;

        // Idle frames: nothing moves, one tick per frame.
        repeat (3) run_frame(-1, 1, -1);
        check_home("idle");

        // First flap enters PLAY, then the bird decelerates upward.
        run_frame(rand_press(), 1, -1);
        check("entry_state", int'(game_state), 1);
        check("entry_bird_y", int'(bird_y), 212);
        run_frame(-1, 1, -1);
        check("rise1_bird_y", int'(bird_y), 205);
        run_frame(-1, 1, -1);
        check("rise2_bird_y", int'(bird_y), 199);

        // Free fall to the ground.
        n = 0;
        while (m_state == 1 && n < 100) begin
            run_frame(-1, 1, -1);
            n++;
        end
        check("ground_death_state", int'(game_state), 2);

        // Presses every fifth frame: only the one at full hold restarts.
        for (int k = 0; k < 35; k++) run_frame((k % 5 == 0) ? rand_press() : -1, 1, -1);
        check_home("restart1");

        // Fly through the gap until the first pipe wraps.
        run_frame(rand_press(), 1, -1);
        n = 0;
        while (m_state == 1 && m_score < 1 && n < 400) begin
            t = m_gap + 60 + int'($urandom_range(0, 10)) - 5;
            run_frame((m_bird > t) ? rand_press() : -1, 1, -1);
            n++;
        end
        check("wrap_state", int'(game_state), 1);
        check("wrap_score", int'(score), 1);

        // Fly above the gap into the next pipe.
        n = 0;
        while (m_state == 1 && n < 400) begin
            t = m_gap - 20 + int'($urandom_range(0, 6)) - 3;
            run_frame((m_bird > t) ? rand_press() : -1, 1, -1);
            n++;
        end
        check("pipe_death_state", int'(game_state), 2);

        // Early press is swallowed; press at full hold returns to IDLE.
        run_frame(rand_press(), 1, -1);
        check("early_press_state", int'(game_state), 2);
        for (int k = 0; k < 30; k++) run_frame(-1, 1, -1);
        run_frame(rand_press(), 1, -1);
        check_home("restart2");
        check("restart2_score", int'(score), 1);

        // Rise on the tick cycle is held for the next frame.
        run_frame(COND_IDX - 1, 1, -1);
        check("coincide_state", int'(game_state), 0);
        run_frame(-1, 1, -1);
        check("carried_state", int'(game_state), 1);
        check("carried_score", int'(score), 0);

        // A tick position held for several cycles fires once.
        run_frame(-1, 3, -1);

        // Asynchronous reset in mid-PLAY, then a clean restart.
        run_frame(-1, 1, -1);
        run_frame(-1, 1, 10);
        run_frame(-1, 1, -1);
        check_home("post_rst");
        run_frame(rand_press(), 1, -1);
        check("post_rst_entry_bird_y", int'(bird_y), 212);

        repeat (4) @(posedge pix_clk);
        check("pending_ticks", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
